// File: rtl/i2c_master_ctrl.sv
// I2C initiator: one command becomes START, {addr,rd}, 1-4 data bytes, STOP on open-drain pins.
// Optional: define I2C_MASTER_STRETCH_EN to honour target clock stretching through a synchronized scl_i.
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic        cmd_rd,
  input  logic [2:0]  cmd_len,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_nack,
  output logic        busy,
  input  logic        scl_i,
  output logic        scl_o,
  output logic        scl_t,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t
);
  if (CLK_DIV < 2) begin : g_bad_div
    $error("CLK_DIV must be >= 2");
  end

  localparam int unsigned QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_RD    = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state, n_state;
  logic [1:0]    q, n_q;
  logic [QW-1:0] qcnt;
  logic [3:0]    bit_r, n_bit;
  logic [1:0]    byte_r, n_byte;
  logic [2:0]    len_r, acc_len;
  logic [6:0]    addr_r;
  logic          rd_r;
  logic [31:0]   wsr, n_wsr, acc_wsr;
  logic [31:0]   rx;
  logic          ack_r, nack_r, n_nack;
  logic          n_scl_t, n_sda_t;
  logic [7:0]    tx_byte, tx_shift;
  logic          last_byte, n_last;
  logic          in_slot, qtick, hold;

  assign scl_o     = 1'b0;
  assign sda_o     = 1'b0;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign in_slot   = (state == S_ADDR) || (state == S_WR) || (state == S_RD);
  assign qtick     = (qcnt == QMAX);

`ifdef I2C_MASTER_STRETCH_EN
  logic scl_meta, scl_sync, rel_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta <= 1'b0;
      scl_sync <= 1'b0;
    end else begin
      scl_meta <= scl_i;
      scl_sync <= scl_meta;
    end
  end
  // Hold at the start of any SCL-released quarter until the line is seen high.
  assign rel_q = (in_slot && q == 2'd2) || (state == S_STOP && q == 2'd1);
  assign hold  = rel_q && (qcnt == '0) && !scl_sync;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold       = 1'b0;
`endif

  // Write bytes are left-aligned at capture so the byte on the wire is always wsr[31:24].
  always_comb begin
    acc_len = (cmd_len == 3'd0 || cmd_len > 3'd4) ? 3'd4 : cmd_len;
    case (acc_len)
      3'd1:    acc_wsr = {cmd_wdata[7:0], 24'h0};
      3'd2:    acc_wsr = {cmd_wdata[15:0], 16'h0};
      3'd3:    acc_wsr = {cmd_wdata[23:0], 8'h0};
      default: acc_wsr = cmd_wdata;
    endcase
  end

  // Next bus position at a quarter boundary, and the pin levels for it.
  always_comb begin
    n_state   = state;
    n_q       = q;
    n_bit     = bit_r;
    n_byte    = byte_r;
    n_wsr     = wsr;
    n_nack    = nack_r;
    last_byte = ({1'b0, byte_r} == len_r - 3'd1);
    case (state)
      S_START: begin
        n_q = q + 2'd1;
        if (q == 2'd1) begin
          n_state = S_ADDR;
          n_q     = '0;
          n_bit   = '0;
        end
      end
      S_ADDR, S_WR, S_RD: begin
        n_q = q + 2'd1;
        if (q == 2'd3) begin
          n_q   = '0;
          n_bit = bit_r + 4'd1;
          if (bit_r == 4'd8) begin
            n_bit = '0;
            if (state != S_RD && ack_r) begin
              n_nack  = 1'b1;
              n_state = S_STOP;
            end else if (state == S_ADDR) begin
              n_state = rd_r ? S_RD : S_WR;
              n_byte  = '0;
            end else if (last_byte) begin
              n_state = S_STOP;
            end else begin
              n_byte = byte_r + 2'd1;
              n_wsr  = {wsr[23:0], 8'h00};
            end
          end
        end
      end
      S_STOP: begin
        n_q = q + 2'd1;
        if (q == 2'd2) begin
          n_state = S_DONE;
          n_q     = '0;
        end
      end
      default: ;
    endcase

    n_last   = ({1'b0, n_byte} == len_r - 3'd1);
    tx_byte  = (n_state == S_ADDR) ? {addr_r, rd_r} : n_wsr[31:24];
    tx_shift = tx_byte << n_bit[2:0];
    n_scl_t  = 1'b1;
    n_sda_t  = 1'b1;
    case (n_state)
      S_START: begin
        n_scl_t = (n_q == 2'd0);
        n_sda_t = 1'b0;
      end
      S_ADDR, S_WR: begin
        n_scl_t = n_q[1];
        n_sda_t = (n_bit == 4'd8) ? 1'b1 : tx_shift[7];
      end
      S_RD: begin
        n_scl_t = n_q[1];
        n_sda_t = (n_bit != 4'd8) || n_last;
      end
      S_STOP: begin
        n_scl_t = (n_q != 2'd0);
        n_sda_t = (n_q == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      q         <= '0;
      qcnt      <= '0;
      bit_r     <= '0;
      byte_r    <= '0;
      len_r     <= '0;
      addr_r    <= '0;
      rd_r      <= 1'b0;
      wsr       <= '0;
      rx        <= '0;
      ack_r     <= 1'b0;
      nack_r    <= 1'b0;
      scl_t     <= 1'b1;
      sda_t     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_r <= cmd_addr;
            rd_r   <= cmd_rd;
            len_r  <= acc_len;
            wsr    <= acc_wsr;
            rx     <= '0;
            ack_r  <= 1'b0;
            nack_r <= 1'b0;
            state  <= S_START;
            q      <= '0;
            qcnt   <= '0;
            bit_r  <= '0;
            byte_r <= '0;
            scl_t  <= 1'b1;
            sda_t  <= 1'b0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          if (!hold) qcnt <= qtick ? '0 : qcnt + QW'(1);
          if (qtick && in_slot && q == 2'd2) begin
            if (bit_r == 4'd8) ack_r <= sda_i;
            else if (state == S_RD) rx <= {rx[30:0], sda_i};
          end
          if (qtick) begin
            state  <= n_state;
            q      <= n_q;
            bit_r  <= n_bit;
            byte_r <= n_byte;
            wsr    <= n_wsr;
            nack_r <= n_nack;
            scl_t  <= n_scl_t;
            sda_t  <= n_sda_t;
            if (n_state == S_DONE) begin
              rsp_valid <= 1'b1;
              rsp_nack  <= n_nack;
              if (rd_r) rsp_rdata <= rx;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural open-drain I2C target on the bus.
module tb_i2c_master_ctrl;
  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_addr = '0;
  logic        cmd_rd = 1'b0;
  logic [2:0]  cmd_len = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_nack;
  logic        busy;
  logic        scl_o, scl_t, sda_o, sda_t;
  logic        scl_bus, sda_bus;
  logic        tgt_sda_low = 1'b0;
  logic        tgt_scl_low = 1'b0;

  always #5 clk = ~clk;

  assign scl_bus = scl_t & ~tgt_scl_low;
  assign sda_bus = sda_t & ~tgt_sda_low;

  i2c_master_ctrl #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rd(cmd_rd), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
    .scl_i(scl_bus), .scl_o(scl_o), .scl_t(scl_t),
    .sda_i(sda_bus), .sda_o(sda_o), .sda_t(sda_t)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_count = 0;
  int t_acc, t_rsp;

  // Target model state
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic       active = 1'b0, rd_mode = 1'b0, rd_stop = 1'b0;
  logic [7:0] sh = '0;
  int         bitn = 0, byten = 0;
  int         n_starts = 0, n_stops = 0;
  logic       ack_addr = 1'b1, ack_data = 1'b1;
  logic [7:0] rd_bytes [8];
  logic [7:0] wlog [$];
  logic       mlog [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rsp_valid) rsp_count <= rsp_count + 1;

  always @(posedge clk) begin
    p_scl <= scl_bus;
    p_sda <= sda_bus;
    if (p_scl && scl_bus && p_sda && !sda_bus) begin
      active      <= 1'b1;
      bitn        <= 0;
      byten       <= 0;
      rd_mode     <= 1'b0;
      rd_stop     <= 1'b0;
      tgt_sda_low <= 1'b0;
      n_starts    <= n_starts + 1;
    end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
      active      <= 1'b0;
      tgt_sda_low <= 1'b0;
      n_stops     <= n_stops + 1;
    end else if (active && !p_scl && scl_bus) begin
      if (bitn < 8) begin
        sh <= {sh[6:0], sda_bus};
        if (bitn == 7) begin
          if (byten == 0) rd_mode <= sda_bus;
          if (byten == 0 || !rd_mode) wlog.push_back({sh[6:0], sda_bus});
        end
        bitn <= bitn + 1;
      end else begin
        if (rd_mode && byten > 0) begin
          mlog.push_back(sda_bus);
          if (sda_bus) rd_stop <= 1'b1;
        end
        bitn  <= 0;
        byten <= byten + 1;
      end
    end else if (active && p_scl && !scl_bus) begin
      if (bitn == 8) tgt_sda_low <= (byten == 0) ? ack_addr : (!rd_mode && ack_data);
      else if (rd_mode && byten > 0 && !rd_stop) tgt_sda_low <= ~rd_bytes[byten-1][7-bitn];
      else tgt_sda_low <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_wlog();
    logic [63:0] v = '0;
    foreach (wlog[i]) v = {v[55:0], wlog[i]};
    return v;
  endfunction

  function automatic logic [63:0] pack_mlog();
    logic [63:0] v = '0;
    foreach (mlog[i]) v = {v[62:0], mlog[i]};
    return v;
  endfunction

  function automatic int exp_lat(input int nbytes);
    return (5 + 36 * (1 + nbytes)) * DIV + 1;
  endfunction

  task automatic check_lat(input string tag, input int exp);
`ifdef I2C_MASTER_STRETCH_EN
    check_eq(tag, 64'(t_rsp - t_acc >= exp), 64'd1);
`else
    check_eq(tag, 64'(t_rsp - t_acc), 64'(exp));
`endif
  endtask

  task automatic clear_logs();
    wlog.delete();
    mlog.delete();
  endtask

  task automatic issue(input logic [6:0] a, input logic r, input logic [2:0] l, input logic [31:0] w);
    @(negedge clk);
    check_eq("ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rd    = r;
    cmd_len   = l;
    cmd_wdata = w;
    t_acc     = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("busy_after_accept", 64'({busy, cmd_ready}), 64'b10);
  endtask

  task automatic wait_rsp(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check_eq("rsp_valid_seen", 64'(rsp_valid), 64'd1);
    t_rsp     = cyc;
    cmd_valid = 1'b0;
    check_eq("busy_at_rsp", 64'({busy, cmd_ready}), 64'b10);
    @(negedge clk);
    check_eq("ready_after_rsp", 64'({busy, cmd_ready}), 64'b01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stops0, starts0, rsp0;
    rd_bytes = '{default: 8'h00};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_pins", 64'({scl_o, scl_t, sda_o, sda_t}), 64'b0101);
    check_eq("rst_ctl", 64'({cmd_ready, busy, rsp_valid, rsp_nack}), 64'b1000);
    check_eq("rst_rdata", 64'(rsp_rdata), 64'h0);

    // Write 4 bytes, all ACKed
    clear_logs();
    stops0 = n_stops;
    issue(7'h2A, 1'b0, 3'd4, 32'h4512F319);
    wait_rsp(5000);
    check_eq("wr4_nack", 64'(rsp_nack), 64'd0);
    check_eq("wr4_nbytes", 64'(wlog.size()), 64'd5);
    check_eq("wr4_bytes", pack_wlog(), 64'h54_4512F319);
    check_eq("wr4_stop", 64'(n_stops - stops0), 64'd1);
    check_lat("wr4_lat", exp_lat(4));

    // Address NACK
    clear_logs();
    ack_addr = 1'b0;
    issue(7'h11, 1'b0, 3'd2, 32'h0000BEEF);
    wait_rsp(5000);
    ack_addr = 1'b1;
    check_eq("anack_nack", 64'(rsp_nack), 64'd1);
    check_eq("anack_nbytes", 64'(wlog.size()), 64'd1);
    check_eq("anack_bytes", pack_wlog(), 64'h22);
    check_lat("anack_lat", exp_lat(0));

    // Read 2 bytes
    clear_logs();
    rd_bytes[0] = 8'hA5;
    rd_bytes[1] = 8'h3C;
    issue(7'h50, 1'b1, 3'd2, 32'h0);
    wait_rsp(5000);
    check_eq("rd_nack", 64'(rsp_nack), 64'd0);
    check_eq("rd_addr_byte", pack_wlog(), 64'hA1);
    check_eq("rd_master_acks", pack_mlog(), 64'b01);
    check_eq("rd_nacks_count", 64'(mlog.size()), 64'd2);
    check_eq("rd_rdata", 64'(rsp_rdata), 64'h0000A53C);
    check_lat("rd_lat", exp_lat(2));

    // cmd_len 0 clamps to 4
    clear_logs();
    issue(7'h2A, 1'b0, 3'd0, 32'h01020304);
    wait_rsp(5000);
    check_eq("clamp_bytes", pack_wlog(), 64'h54_01020304);
    check_eq("clamp_rdata_kept", 64'(rsp_rdata), 64'h0000A53C);
    check_lat("clamp_lat", exp_lat(4));

    // cmd_valid held during busy with a different address
    clear_logs();
    starts0 = n_starts;
    rsp0    = rsp_count;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 7'h2A;
    cmd_rd    = 1'b0;
    cmd_len   = 3'd1;
    cmd_wdata = 32'h00000033;
    t_acc     = cyc;
    @(negedge clk);
    cmd_addr  = 7'h0F;
    cmd_wdata = 32'hFFFFFFFF;
    wait_rsp(5000);
    repeat (20) @(negedge clk);
    check_eq("hold_bytes", pack_wlog(), 64'h5433);
    check_eq("hold_starts", 64'(n_starts - starts0), 64'd1);
    check_eq("hold_rsp_count", 64'(rsp_count - rsp0), 64'd1);
    check_eq("hold_idle", 64'({busy, cmd_ready}), 64'b01);
    check_lat("hold_lat", exp_lat(1));

    // Reset during the second data byte
    clear_logs();
    rsp0 = rsp_count;
    issue(7'h2A, 1'b0, 3'd4, 32'h61322387);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (byten == 2 && bitn == 3) break;
    end
    check_eq("mid_wait_reached", 64'(byten == 2 && bitn == 3), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_pins", 64'({scl_t, sda_t}), 64'b11);
    check_eq("mid_rst_ready", 64'({cmd_ready, busy}), 64'b10);
    check_eq("mid_rst_rdata", 64'(rsp_rdata), 64'h0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check_eq("mid_no_rsp", 64'(rsp_count - rsp0), 64'd0);
    check_eq("mid_bytes_before_rst", pack_wlog(), 64'h5461);
    clear_logs();
    issue(7'h2A, 1'b0, 3'd1, 32'h0000005A);
    wait_rsp(5000);
    check_eq("post_rst_nack", 64'(rsp_nack), 64'd0);
    check_eq("post_rst_bytes", pack_wlog(), 64'h545A);
    check_lat("post_rst_lat", exp_lat(1));

`ifdef I2C_MASTER_STRETCH_EN
    // Target stretches SCL for 100 cycles after the address ACK slot
    clear_logs();
    issue(7'h2A, 1'b0, 3'd1, 32'h000000A7);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (byten == 1 && !scl_bus) break;
    end
    tgt_scl_low = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("stretch_released_scl", 64'(scl_t), 64'd1);
    tgt_scl_low = 1'b0;
    wait_rsp(5000);
    check_eq("stretch_bytes", pack_wlog(), 64'h54A7);
    check_eq("stretch_lat", 64'(t_rsp - t_acc >= exp_lat(1) + 100), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
